regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 185 ++++++++++++++++++
 tb/tb_regfile_writeback.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: register-file write-back stage.
//
// Merges an unbuffered ALU result stream and a buffered load result stream
// onto the single register-file write port. It also keeps a per-register
// pending-write scoreboard.
//
// Optional feature: define WB_BYPASS_EN to add the fwd_hit1/2 and
// fwd_data1/2 outputs. These forward the value being written this cycle to
// the two lookup ports.
//
// Handshake semantics (both result inputs): a transfer happens on a posedge
// where valid && ready are both high. The producer must hold rd/data stable
// while valid is high and ready is low.
//  - ld_ready depends only on FIFO occupancy. It does not look at ld_valid
//    or at a same-cycle pop.
//  - alu_ready is the ALU grant. It depends combinationally on alu_valid.
//  - While rst is high, neither ready is asserted.

module regfile_writeback #(
    parameter int LD_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [31:0] rf_wd,
    output logic [31:0] busy,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_busy1,
    output logic        chk_busy2
`ifdef WB_BYPASS_EN
    ,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
`endif
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Source that won the most recent contended cycle.
    typedef enum logic {
        SRC_FIFO = 1'b0,
        SRC_ALU  = 1'b1
    } src_e;

    // Load FIFO storage and bookkeeping.
    logic [4:0]    fifo_rd   [LD_DEPTH];
    logic [31:0]   fifo_data [LD_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    src_e          last_grant;

    logic          alu_pend;
    logic          fifo_pend;
    logic          contend;
    logic          grant_alu;
    logic          grant_fifo;
    logic          push;
    logic          pop;
    logic [31:0]   busy_next;

    // Arbitration: a lone requester always wins. When both sources request,
    // the one that lost the previous contention wins this one.
    always_comb begin
        alu_pend   = alu_valid && !rst;
        fifo_pend  = (count != '0) && !rst;
        contend    = alu_pend && fifo_pend;
        grant_alu  = alu_pend && (!fifo_pend || (last_grant == SRC_FIFO));
        grant_fifo = fifo_pend && !grant_alu;
        alu_ready  = grant_alu;
        ld_ready   = !rst && (count < CW'(LD_DEPTH));
        push       = ld_valid && ld_ready;
        pop        = grant_fifo;
    end

    // Write-port mux. Writes to x0 still consume their source, but they
    // never raise rf_we.
    always_comb begin
        rf_addr = 5'd0;
        rf_wd   = 32'd0;
        if (grant_alu) begin
            rf_addr = alu_rd;
            rf_wd   = alu_data;
        end else if (grant_fifo) begin
            rf_addr = fifo_rd[rptr];
            rf_wd   = fifo_data[rptr];
        end
        rf_we = (grant_alu || grant_fifo) && (rf_addr != 5'd0);
    end

    // FIFO payload storage. Stale entries are harmless because the pointers
    // and count are what reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= ld_rd;
            fifo_data[wptr] <= ld_data;
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally at a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Round-robin memory. It only moves on cycles where both sources
    // compete. It resets to FIFO so that the ALU wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= SRC_FIFO;
        end else if (contend) begin
            last_grant <= grant_alu ? SRC_ALU : SRC_FIFO;
        end
    end

    // Scoreboard next state. The clear is applied first, so a same-cycle
    // issue to the same register leaves its bit set. x0 is never pending.
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    // Scoreboard lookups.
    always_comb begin
        chk_busy1 = busy[chk_addr1];
        chk_busy2 = busy[chk_addr2];
    end

`ifdef WB_BYPASS_EN
    // Forward the value being written this cycle to the lookup ports.
    always_comb begin
        fwd_hit1  = rf_we && (rf_addr == chk_addr1);
        fwd_hit2  = rf_we && (rf_addr == chk_addr2);
        fwd_data1 = fwd_hit1 ? rf_wd : 32'd0;
        fwd_data2 = fwd_hit2 ? rf_wd : 32'd0;
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: self-checking bench for regfile_writeback.
// The reference model is a queue of pending loads, a busy bit-vector and
// the round-robin winner of the previous contention.
// Build with WB_BYPASS_EN defined to also cover the forwarding outputs.

module tb_regfile_writeback;

  localparam int LD_DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rf_addr;
  logic        rf_we;
  logic [31:0] rf_wd;
  logic [31:0] busy;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy1;
  logic        chk_busy2;
`ifdef WB_BYPASS_EN
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
`endif

  regfile_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_addr(rf_addr), .rf_we(rf_we), .rf_wd(rf_wd), .busy(busy),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
`ifdef WB_BYPASS_EN
    ,
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and check helper ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [36:0] exp_q[$];      // pending loads, {rd, data}, oldest first
  logic [31:0] m_busy;
  logic        m_last_alu;    // 1 = ALU won the last contention
  logic        m_fp, m_galu, m_gfifo, m_we, m_ldr;
  logic [4:0]  m_addr;
  logic [31:0] m_wd;
  logic [36:0] m_head;

  // Compare process: inputs are stable here. The model checks this cycle's
  // outputs, then advances to the state after the coming posedge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
      chk("rst_ld_ready",  {31'd0, ld_ready},  32'd0);
      chk("rst_rf_we",     {31'd0, rf_we},     32'd0);
      chk("rst_rf_addr",   {27'd0, rf_addr},   32'd0);
      chk("rst_rf_wd",     rf_wd,              32'd0);
      exp_q.delete();
      m_busy     = 32'd0;
      m_last_alu = 1'b0;
    end else begin
      m_fp    = (exp_q.size() != 0);
      m_galu  = alu_valid && (!m_fp || !m_last_alu);
      m_gfifo = m_fp && !m_galu;
      m_head  = m_fp ? exp_q[0] : 37'd0;
      m_addr  = m_galu ? alu_rd : (m_gfifo ? m_head[36:32] : 5'd0);
      m_wd    = m_galu ? alu_data : (m_gfifo ? m_head[31:0] : 32'd0);
      m_we    = (m_galu || m_gfifo) && (m_addr != 5'd0);
      m_ldr   = (exp_q.size() < LD_DEPTH);
      chk("alu_ready", {31'd0, alu_ready}, {31'd0, m_galu});
      chk("ld_ready",  {31'd0, ld_ready},  {31'd0, m_ldr});
      chk("rf_we",     {31'd0, rf_we},     {31'd0, m_we});
      chk("rf_addr",   {27'd0, rf_addr},   {27'd0, m_addr});
      chk("rf_wd",     rf_wd,              m_wd);
      chk("busy",      busy,               m_busy);
      chk("chk_busy1", {31'd0, chk_busy1}, {31'd0, m_busy[chk_addr1]});
      chk("chk_busy2", {31'd0, chk_busy2}, {31'd0, m_busy[chk_addr2]});
`ifdef WB_BYPASS_EN
      chk("fwd_hit1",  {31'd0, fwd_hit1}, {31'd0, m_we && m_addr == chk_addr1});
      chk("fwd_hit2",  {31'd0, fwd_hit2}, {31'd0, m_we && m_addr == chk_addr2});
      chk("fwd_data1", fwd_data1, (m_we && m_addr == chk_addr1) ? m_wd : 32'd0);
      chk("fwd_data2", fwd_data2, (m_we && m_addr == chk_addr2) ? m_wd : 32'd0);
`endif
      if (alu_valid && m_fp) m_last_alu = m_galu;
      if (m_we) m_busy[m_addr] = 1'b0;
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (m_gfifo) void'(exp_q.pop_front());
      if (ld_valid && m_ldr) exp_q.push_back({ld_rd, ld_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_begin();
    @(posedge clk);
    #1;
    rst = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
  endtask

  task automatic reset_dut();
    cyc_begin();
    rst = 1'b1;
  endtask

  // Hand-computed tables for the contention run (ALU rd 3, load rd 4).
  logic [4:0] con_addr_tab [8] = '{5'd3, 5'd3, 5'd4, 5'd3, 5'd4, 5'd3, 5'd4, 5'd3};
  logic       con_ldr_tab  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    reset_dut();

    // Reset state.
    cyc_begin();
    @(negedge clk);
    chk("lit_reset_busy",     busy,               32'd0);
    chk("lit_reset_ld_ready", {31'd0, ld_ready},  32'd1);
    chk("lit_reset_rf_we",    {31'd0, rf_we},     32'd0);

    // ALU-only write, same cycle.
    cyc_begin();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    @(negedge clk);
    chk("lit_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("lit_alu_we",    {31'd0, rf_we},     32'd1);
    chk("lit_alu_addr",  {27'd0, rf_addr},   32'd5);
    chk("lit_alu_wd",    rf_wd,              32'h1234_5678);

    // Contention and FIFO fill: both sources valid every cycle.
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      cyc_begin();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA00 + k;
      ld_valid = 1'b1;  ld_rd = 5'd4;  ld_data = 32'h100 + k;
      @(negedge clk);
      chk("lit_con_addr", {27'd0, rf_addr}, {27'd0, con_addr_tab[k]});
      chk("lit_con_ldr",  {31'd0, ld_ready}, {31'd0, con_ldr_tab[k]});
      if (k == 2 || k == 4 || k == 6)
        chk("lit_con_order", rf_wd, 32'h100 + (k / 2) - 1);
    end

    // x0 load: popped, never written, busy untouched.
    reset_dut();
    cyc_begin();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hDEAD_BEEF;
    issue_valid = 1'b1; issue_rd = 5'd9;
    cyc_begin();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1;
    @(negedge clk);
    chk("lit_x0_we",   {31'd0, rf_we},    32'd0);
    chk("lit_x0_wd",   rf_wd,             32'hDEAD_BEEF);
    chk("lit_x0_ldr",  {31'd0, ld_ready}, 32'd1);
    chk("lit_x0_busy", busy,              32'h0000_0200);
    cyc_begin();
    @(negedge clk);
    chk("lit_x0_we2",  {31'd0, rf_we},    32'd0);
    chk("lit_x0_wd2",  rf_wd,             32'h1);

    // Scoreboard set / set-wins / clear.
    cyc_begin();
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc_begin();
    chk_addr1 = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    chk("lit_sb_chk1", {31'd0, chk_busy1}, 32'd1);
    chk("lit_sb_we",   {31'd0, rf_we},     32'd1);
    cyc_begin();
    chk_addr1 = 5'd7;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
    @(negedge clk);
    chk("lit_sb_setwins", {31'd0, chk_busy1}, 32'd1);
    cyc_begin();
    chk_addr1 = 5'd7; chk_addr2 = 5'd9;
    @(negedge clk);
    chk("lit_sb_clear", {31'd0, chk_busy1}, 32'd0);
    chk("lit_sb_other", {31'd0, chk_busy2}, 32'd1);

    // Reset mid-operation: 3 loads queued, busy = 0xF0.
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      cyc_begin();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hB00 + k;
      ld_valid = 1'b1;  ld_rd = 5'd8;  ld_data = 32'hC00 + k;
      issue_valid = 1'b1; issue_rd = 5'(4 + k);
    end
    cyc_begin();
    rst = 1'b1;
    @(negedge clk);
    chk("lit_mid_busy_pre", busy, 32'h0000_00F0);
    cyc_begin();
    @(negedge clk);
    chk("lit_mid_busy", busy,               32'd0);
    chk("lit_mid_we",   {31'd0, rf_we},     32'd0);
    chk("lit_mid_ldr",  {31'd0, ld_ready},  32'd1);
    cyc_begin();
    @(negedge clk);
    chk("lit_mid_we2",  {31'd0, rf_we},     32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc_begin();
      rst         = ($urandom_range(0, 99) == 0);
      alu_valid   = ($urandom_range(0, 99) < 45);
      alu_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      alu_data    = $urandom;
      ld_valid    = ($urandom_range(0, 99) < 60);
      ld_rd       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ld_data     = $urandom;
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd    = 5'($urandom_range(0, 7));
      chk_addr1   = 5'($urandom_range(0, 7));
      chk_addr2   = 5'($urandom_range(0, 31));
    end

    cyc_begin();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
